// File: rtl/hc595_pkg.sv
// Shared constants and the segment decode helper for the 74HC595 receive monitor.
package hc595_pkg;

    localparam int FRAME_BITS = 16;

    // Field positions inside the 16-bit latched word {marker, seg[6:0], sel[7:0]}
    localparam int MARKER_BIT = 15;
    localparam int SEG_MSB    = 14;
    localparam int SEG_LSB    = 8;
    localparam int SEL_MSB    = 7;
    localparam int SEL_LSB    = 0;

    // Active-low {g,f,e,d,c,b,a} patterns; entry n is the glyph for nibble n
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Returns {hit, nibble}; hit=0 means the pattern is not a hex glyph
    function automatic logic [4:0] seg_to_nibble(input logic [6:0] seg);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_LUT[i]) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/hc595_edge_sync.sv
// Multi-flop synchronizer for one asynchronous link line plus a rising-edge flag.
module hc595_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_sync,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the line through the sync chain and keep last synced value for edge detect
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/hc595_rx_monitor.sv
// Rebuilds 74HC595 frames from the serial link and decodes them into a display image.
module hc595_rx_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16,
    parameter int DIGITS      = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  SH_CP,
    input  logic                  ST_CP,
    input  logic                  DS,
    output logic [15:0]           frame_word,
    output logic                  frame_valid,
    output logic [4*DIGITS-1:0]   disp_data,
    output logic                  scan_done,
    output logic                  frame_err,
    output logic [7:0]            err_count
);

    import hc595_pkg::*;

    localparam int IDXW = $clog2(DIGITS);

    logic w_sh_rise, w_st_rise, w_ds_sync;
    logic w_sh_sync_unused, w_st_sync_unused, w_ds_rise_unused;

    hc595_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sh (
        .i_clk(Clk), .i_rst(Rst), .i_d(SH_CP), .o_sync(w_sh_sync_unused), .o_rise(w_sh_rise)
    );
    hc595_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_st (
        .i_clk(Clk), .i_rst(Rst), .i_d(ST_CP), .o_sync(w_st_sync_unused), .o_rise(w_st_rise)
    );
    hc595_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_ds (
        .i_clk(Clk), .i_rst(Rst), .i_d(DS), .o_sync(w_ds_sync), .o_rise(w_ds_rise_unused)
    );

    logic [15:0] r_shreg;
    logic [4:0]  r_bit_cnt;
    logic [4:0]  r_lat_cnt;   // bit count captured with the latched word
    logic [15:0] r_frame_word;
    logic        r_frame_valid;

    // Shift/latch stage: latch sees the pre-shift register when both edges coincide
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_shreg       <= '0;
            r_bit_cnt     <= '0;
            r_lat_cnt     <= '0;
            r_frame_word  <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            if (w_sh_rise) r_shreg <= {r_shreg[14:0], w_ds_sync};
            if (w_st_rise) begin
                r_frame_word  <= r_shreg;
                r_lat_cnt     <= r_bit_cnt;
                r_frame_valid <= 1'b1;
                r_bit_cnt     <= w_sh_rise ? 5'd1 : 5'd0;
            end else if (w_sh_rise && r_bit_cnt != 5'd31) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
        end
    end

    logic              w_marker;
    logic [6:0]        w_seg;
    logic [DIGITS-1:0] w_sel;
    logic [4:0]        w_lut;
    logic              w_onehot;
    logic              w_reject;
    logic [IDXW-1:0]   w_idx;
    logic [DIGITS-1:0] w_mask_nxt;
    logic [DIGITS-1:0] r_mask;

    assign w_marker = r_frame_word[MARKER_BIT];
    assign w_seg    = r_frame_word[SEG_MSB:SEG_LSB];
    assign w_sel    = r_frame_word[SEL_MSB:SEL_LSB];
    assign w_lut    = seg_to_nibble(w_seg);
    assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
    assign w_reject = !w_marker || (r_lat_cnt != 5'(FRAME_BITS)) || !w_onehot || !w_lut[4];

    // Digit index from the one-hot select; only meaningful when w_onehot holds
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_sel[i]) w_idx = IDXW'(i);
        end
        w_mask_nxt = r_mask | (DIGITS'(1) << w_idx);
    end

    logic [4*DIGITS-1:0] r_disp_data;
    logic                r_scan_done;
    logic                r_frame_err;
    logic [7:0]          r_err_count;

    // Decode stage: update the display image or count the rejected frame
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_disp_data <= '0;
            r_mask      <= '0;
            r_scan_done <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_scan_done <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_frame_valid) begin
                if (w_reject) begin
                    r_frame_err <= 1'b1;
                    if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                end else begin
                    r_disp_data[4*w_idx +: 4] <= w_lut[3:0];
                    if (&w_mask_nxt) begin
                        r_scan_done <= 1'b1;
                        r_mask      <= '0;
                    end else begin
                        r_mask <= w_mask_nxt;
                    end
                end
            end
        end
    end

    assign frame_word  = r_frame_word;
    assign frame_valid = r_frame_valid;
    assign disp_data   = r_disp_data;
    assign scan_done   = r_scan_done;
    assign frame_err   = r_frame_err;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_hc595_rx_monitor.sv
// Directed self-checking bench for hc595_rx_monitor.
module tb_hc595_rx_monitor;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        SH_CP = 1'b0;
    logic        ST_CP = 1'b0;
    logic        DS = 1'b0;
    logic [15:0] frame_word;
    logic        frame_valid;
    logic [31:0] disp_data;
    logic        scan_done;
    logic        frame_err;
    logic [7:0]  err_count;

    hc595_rx_monitor #(.SYNC_STAGES(2), .FRAME_BITS(16), .DIGITS(8)) dut (
        .Clk(Clk), .Rst(Rst), .SH_CP(SH_CP), .ST_CP(ST_CP), .DS(DS),
        .frame_word(frame_word), .frame_valid(frame_valid), .disp_data(disp_data),
        .scan_done(scan_done), .frame_err(frame_err), .err_count(err_count)
    );

    always #10 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_fv = 0;
    int n_scan = 0;
    int n_ferr = 0;

    // Pulse counters sampled away from the active edge
    always @(negedge Clk) begin
        if (frame_valid) n_fv++;
        if (scan_done)   n_scan++;
        if (frame_err)   n_ferr++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    task automatic shift_bit(input logic b);
        @(negedge Clk);
        DS = b;
        wait_n(2);
        SH_CP = 1'b1;
        wait_n(3);
        SH_CP = 1'b0;
        wait_n(3);
    endtask

    task automatic latch();
        wait_n(2);
        ST_CP = 1'b1;
        wait_n(3);
        ST_CP = 1'b0;
        wait_n(3);
    endtask

    task automatic shift_bits(input logic [15:0] w, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic send_word(input logic [15:0] w);
        shift_bits(w, 16);
        latch();
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        wait_n(3);
        Rst = 1'b0;
        wait_n(1);
    endtask

    logic [15:0] scan_words [8];
    int fv0, sc0, fe0, lat;

    initial begin
        scan_words[0] = 16'hF901; scan_words[1] = 16'hA402;
        scan_words[2] = 16'hB004; scan_words[3] = 16'h9908;
        scan_words[4] = 16'h9210; scan_words[5] = 16'h8220;
        scan_words[6] = 16'hF840; scan_words[7] = 16'h8080;

        wait_n(4);
        Rst = 1'b0;
        wait_n(1);
        chk("rst_frame_word", 32'(frame_word), 32'h0);
        chk("rst_disp", disp_data, 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        chk("rst_pulses", {29'h0, frame_valid, scan_done, frame_err}, 32'h0);

        // Reset in the middle of a frame discards the partial shift and bit count
        shift_bits(16'h01FF, 9);
        do_reset();
        fv0 = n_fv; fe0 = n_ferr;
        send_word(16'hC001);
        chk("midrst_fv", 32'(n_fv - fv0), 32'd1);
        chk("midrst_word", 32'(frame_word), 32'hC001);
        chk("midrst_digit0", 32'(disp_data[3:0]), 32'h0);
        chk("midrst_ferr", 32'(n_ferr - fe0), 32'd0);
        chk("midrst_errcnt", 32'(err_count), 32'd0);

        // Latch latency from the ST_CP pin rise, counted in Clk edges
        shift_bits(16'h9204, 16);
        wait_n(2);
        ST_CP = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            if (frame_valid && lat == 0) lat = k;
        end
        ST_CP = 1'b0;
        wait_n(3);
        chk("lat_fv", 32'(lat), 32'd3);
        chk("lat_word", 32'(frame_word), 32'h9204);
        chk("lat_digit2", 32'(disp_data[11:8]), 32'h5);

        // Full scan of eight digits from a clean mask
        do_reset();
        sc0 = n_scan;
        for (int i = 0; i < 7; i++) send_word(scan_words[i]);
        chk("scan_early", 32'(n_scan - sc0), 32'd0);
        send_word(scan_words[7]);
        chk("scan_pulse", 32'(n_scan - sc0), 32'd1);
        chk("scan_disp", disp_data, 32'h87654321);
        send_word(16'hF901);
        chk("scan_ninth", 32'(n_scan - sc0), 32'd1);

        // Each rejected frame counts, and the image stays put
        fe0 = n_ferr;
        shift_bits(16'h4001, 15);
        latch();
        chk("rej_len_cnt", 32'(err_count), 32'd1);
        send_word(16'h4001);
        chk("rej_marker_cnt", 32'(err_count), 32'd2);
        send_word(16'hC003);
        chk("rej_sel_cnt", 32'(err_count), 32'd3);
        send_word(16'hFF01);
        chk("rej_seg_cnt", 32'(err_count), 32'd4);
        chk("rej_seg_word", 32'(frame_word), 32'hFF01);
        chk("rej_pulses", 32'(n_ferr - fe0), 32'd4);
        chk("rej_disp", disp_data, 32'h87654321);

        // Coincident SH_CP/ST_CP rise: latch takes the word before the extra bit
        shift_bits(16'hC001, 16);
        @(negedge Clk);
        DS = 1'b1;
        wait_n(2);
        SH_CP = 1'b1;
        ST_CP = 1'b1;
        wait_n(3);
        SH_CP = 1'b0;
        ST_CP = 1'b0;
        wait_n(3);
        chk("sim_word", 32'(frame_word), 32'hC001);
        chk("sim_disp", disp_data, 32'h87654320);
        chk("sim_errcnt", 32'(err_count), 32'd4);
        // Counter restarted at 1 so a bare latch is a length error
        latch();
        chk("sim_restart_cnt", 32'(err_count), 32'd5);

        // Error counter saturation
        for (int i = 0; i < 256; i++) latch();
        chk("sat_errcnt", 32'(err_count), 32'd255);
        chk("sat_disp", disp_data, 32'h87654320);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
